// File: rtl/instr_register_pipe_pkg.sv
// Shared types for the instruction register pipe: opcode encoding, iterative
// sequencer states and the single-cycle/iterative classification.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7,
        POW   = 4'd8
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        WB   = 2'd2
    } iter_state_t;

    function automatic logic is_iterative(opcode_t op);
        return (op == DIV) || (op == MOD) || (op == POW);
    endfunction

endpackage

// File: rtl/instr_register_pipe_if.sv
// Load/read bus of the instruction register pipe; the requester is the master.
interface instr_register_pipe_if #(
    parameter int OP_WIDTH = 32,
    parameter int DEPTH    = 32
);
    localparam int AW        = $clog2(DEPTH);
    localparam int RES_WIDTH = 2 * OP_WIDTH;

    logic                        load_valid;
    logic                        load_ready;
    instr_register_pkg::opcode_t opcode;
    logic signed [OP_WIDTH-1:0]  operand_a;
    logic signed [OP_WIDTH-1:0]  operand_b;
    logic [AW-1:0]               write_pointer;
    logic [AW-1:0]               read_pointer;
    instr_register_pkg::opcode_t rd_opcode;
    logic signed [OP_WIDTH-1:0]  rd_operand_a;
    logic signed [OP_WIDTH-1:0]  rd_operand_b;
    logic [RES_WIDTH-1:0]        rd_result;
    logic                        rd_err;
    logic                        rd_valid;
    logic                        busy;

    modport master (
        output load_valid, opcode, operand_a, operand_b, write_pointer, read_pointer,
        input  load_ready, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err,
               rd_valid, busy
    );

    modport slave (
        input  load_valid, opcode, operand_a, operand_b, write_pointer, read_pointer,
        output load_ready, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err,
               rd_valid, busy
    );

endinterface

// File: rtl/instr_register_pipe_iter_unit.sv
// Iterative engine: restoring signed divider and MSB-first square-and-multiply
// power, one operand bit per cycle, OP_WIDTH cycles after start.
module instr_iter_unit
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  opcode_t                 op,
    input  logic [OP_WIDTH-1:0]     a,
    input  logic [OP_WIDTH-1:0]     b,
    output logic                    done,
    output logic [2*OP_WIDTH-1:0]   res,
    output logic                    err
);
    localparam int RES_WIDTH = 2 * OP_WIDTH;
    localparam int CW        = $clog2(OP_WIDTH + 1);

    logic                 run_q, run_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 pow_q, pow_d, mod_q, mod_d, err_q, err_d;
    logic                 qneg_q, qneg_d, rneg_q, rneg_d;
    logic [OP_WIDTH-1:0]  dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
    logic [OP_WIDTH-1:0]  exp_q, exp_d, abs_a, abs_b;
    logic [RES_WIDTH-1:0] acc_q, acc_d, base_q, base_d, sq, mag;
    logic [OP_WIDTH:0]    trial;

    // done marks the cycle whose closing edge performs the final step.
    assign done = run_q && (cnt_q == CW'(OP_WIDTH - 1));

    always_comb begin
        run_d  = run_q;  cnt_d  = cnt_q;  pow_d  = pow_q;  mod_d = mod_q;
        err_d  = err_q;  qneg_d = qneg_q; rneg_d = rneg_q;
        dvd_d  = dvd_q;  dvs_d  = dvs_q;  rem_d  = rem_q;  quo_d = quo_q;
        exp_d  = exp_q;  acc_d  = acc_q;  base_d = base_q;
        abs_a  = a[OP_WIDTH-1] ? (~a + 1'b1) : a;
        abs_b  = b[OP_WIDTH-1] ? (~b + 1'b1) : b;
        trial  = {rem_q, dvd_q[OP_WIDTH-1]};
        sq     = acc_q * acc_q;
        if (start) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            pow_d  = (op == POW);
            mod_d  = (op == MOD);
            err_d  = (op == POW) ? b[OP_WIDTH-1] : (b == '0);
            qneg_d = a[OP_WIDTH-1] ^ b[OP_WIDTH-1];
            rneg_d = a[OP_WIDTH-1];
            dvd_d  = abs_a;
            dvs_d  = abs_b;
            rem_d  = '0;
            quo_d  = '0;
            exp_d  = b;
            acc_d  = RES_WIDTH'(1);
            base_d = {{(RES_WIDTH-OP_WIDTH){a[OP_WIDTH-1]}}, a};
        end else if (run_q) begin
            cnt_d = cnt_q + 1'b1;
            run_d = !done;
            dvd_d = dvd_q << 1;
            if (trial >= {1'b0, dvs_q}) begin
                rem_d = OP_WIDTH'(trial - {1'b0, dvs_q});
                quo_d = {quo_q[OP_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = trial[OP_WIDTH-1:0];
                quo_d = {quo_q[OP_WIDTH-2:0], 1'b0};
            end
            exp_d = exp_q << 1;
            acc_d = exp_q[OP_WIDTH-1] ? sq * base_q : sq;
        end
    end

    // Divider works on magnitudes; signs are restored here.
    always_comb begin
        mag = mod_q ? {{OP_WIDTH{1'b0}}, rem_q} : {{OP_WIDTH{1'b0}}, quo_q};
        if (err_q)
            res = '0;
        else if (pow_q)
            res = acc_q;
        else if (mod_q ? rneg_q : qneg_q)
            res = ~mag + 1'b1;
        else
            res = mag;
    end
    assign err = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q  <= 1'b0; cnt_q  <= '0;   pow_q  <= 1'b0; mod_q <= 1'b0;
            err_q  <= 1'b0; qneg_q <= 1'b0; rneg_q <= 1'b0;
            dvd_q  <= '0;   dvs_q  <= '0;   rem_q  <= '0;   quo_q <= '0;
            exp_q  <= '0;   acc_q  <= '0;   base_q <= '0;
        end else begin
            run_q  <= run_d;  cnt_q  <= cnt_d;  pow_q  <= pow_d;  mod_q <= mod_d;
            err_q  <= err_d;  qneg_q <= qneg_d; rneg_q <= rneg_d;
            dvd_q  <= dvd_d;  dvs_q  <= dvs_d;  rem_q  <= rem_d;  quo_q <= quo_d;
            exp_q  <= exp_d;  acc_q  <= acc_d;  base_q <= base_d;
        end
    end

endmodule

// File: rtl/instr_register_pipe.sv
// Instruction register file with a one-stage writeback pipe for single-cycle ops
// and a sequencer that stalls the load port around the iterative unit.
module instr_register_pipe
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH = 32,
    parameter int DEPTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instr_register_pipe_if.slave  bus
);
    localparam int AW        = $clog2(DEPTH);
    localparam int RES_WIDTH = 2 * OP_WIDTH;

    typedef struct packed {
        opcode_t              opc;
        logic [OP_WIDTH-1:0]  a;
        logic [OP_WIDTH-1:0]  b;
        logic [RES_WIDTH-1:0] res;
        logic                 err;
        logic                 vld;
    } slot_t;

    slot_t                slots_q [DEPTH];
    slot_t                slots_d [DEPTH];
    slot_t                stg_q, stg_d, rd_slot;
    logic                 stg_vld_q, stg_vld_d;
    logic [AW-1:0]        stg_ptr_q, stg_ptr_d;
    iter_state_t          state_q, state_d;
    logic                 ready_q, ready_d, busy_q, busy_d;
    opcode_t              iop_q, iop_d;
    logic [OP_WIDTH-1:0]  ia_q, ia_d, ib_q, ib_d;
    logic [AW-1:0]        iptr_q, iptr_d;
    logic                 accept, iter_start, iter_done, iter_err, alu_err;
    logic [RES_WIDTH-1:0] iter_res, alu_res;

    function automatic logic [RES_WIDTH-1:0] sext(input logic [OP_WIDTH-1:0] v);
        return {{(RES_WIDTH-OP_WIDTH){v[OP_WIDTH-1]}}, v};
    endfunction

    instr_iter_unit #(.OP_WIDTH(OP_WIDTH)) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (iter_start),
        .op      (bus.opcode),
        .a       (bus.operand_a),
        .b       (bus.operand_b),
        .done    (iter_done),
        .res     (iter_res),
        .err     (iter_err)
    );

    // Iterative opcodes never reach the stage register, so their ALU value is unused.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (bus.opcode)
            ZERO, DIV, MOD, POW: alu_res = '0;
            PASSA:   alu_res = sext(bus.operand_a);
            PASSB:   alu_res = sext(bus.operand_b);
            ADD:     alu_res = sext(bus.operand_a) + sext(bus.operand_b);
            SUB:     alu_res = sext(bus.operand_a) - sext(bus.operand_b);
            MULT:    alu_res = sext(bus.operand_a) * sext(bus.operand_b);
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        accept     = bus.load_valid && ready_q;
        iter_start = accept && is_iterative(bus.opcode);
        stg_vld_d  = accept && !iter_start;
        stg_d      = stg_q;
        stg_ptr_d  = stg_ptr_q;
        iop_d      = iop_q;
        ia_d       = ia_q;
        ib_d       = ib_q;
        iptr_d     = iptr_q;
        if (stg_vld_d) begin
            stg_d     = '{opc: bus.opcode, a: bus.operand_a, b: bus.operand_b,
                          res: alu_res, err: alu_err, vld: 1'b1};
            stg_ptr_d = bus.write_pointer;
        end
        if (iter_start) begin
            iop_d  = bus.opcode;
            ia_d   = bus.operand_a;
            ib_d   = bus.operand_b;
            iptr_d = bus.write_pointer;
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (iter_start) state_d = ITER;
            ITER:    if (iter_done)  state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = !ready_d;

        // The load port is closed around WB, so the two write sources never collide.
        slots_d = slots_q;
        if (stg_vld_q)
            slots_d[stg_ptr_q] = stg_q;
        else if (state_q == WB)
            slots_d[iptr_q] = '{opc: iop_q, a: ia_q, b: ib_q, res: iter_res,
                                err: iter_err, vld: 1'b1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
            stg_q     <= '0;
            stg_vld_q <= 1'b0;
            stg_ptr_q <= '0;
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            iop_q     <= ZERO;
            ia_q      <= '0;
            ib_q      <= '0;
            iptr_q    <= '0;
        end else begin
            slots_q   <= slots_d;
            stg_q     <= stg_d;
            stg_vld_q <= stg_vld_d;
            stg_ptr_q <= stg_ptr_d;
            state_q   <= state_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            iop_q     <= iop_d;
            ia_q      <= ia_d;
            ib_q      <= ib_d;
            iptr_q    <= iptr_d;
        end
    end

    assign rd_slot          = slots_q[bus.read_pointer];
    assign bus.rd_opcode    = rd_slot.opc;
    assign bus.rd_operand_a = rd_slot.a;
    assign bus.rd_operand_b = rd_slot.b;
    assign bus.rd_result    = rd_slot.res;
    assign bus.rd_err       = rd_slot.err;
    assign bus.rd_valid     = rd_slot.vld;
    assign bus.load_ready   = ready_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Randomized and directed bench for instr_register_pipe (OP_WIDTH=8, DEPTH=8)
// against an arithmetic reference model of the register file.
module tb_instr_register_pipe;
    import instr_register_pkg::*;

    localparam int OPW      = 8;
    localparam int DEPTH    = 8;
    localparam int ITER_LOW = OPW + 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    instr_register_pipe_if #(.OP_WIDTH(OPW), .DEPTH(DEPTH)) bus();
    instr_register_pipe #(.OP_WIDTH(OPW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    opcode_t     m_opc [DEPTH];
    logic [7:0]  m_a   [DEPTH];
    logic [7:0]  m_b   [DEPTH];
    logic [15:0] m_res [DEPTH];
    logic        m_err [DEPTH];
    logic        m_vld [DEPTH];

    function automatic void ref_calc(input opcode_t op, input logic signed [7:0] a,
                                     input logic signed [7:0] b,
                                     output logic [15:0] res, output logic err);
        longint la = a;
        longint lb = b;
        longint r  = 0;
        err = 1'b0;
        case (op)
            ZERO:  r = 0;
            PASSA: r = la;
            PASSB: r = lb;
            ADD:   r = la + lb;
            SUB:   r = la - lb;
            MULT:  r = la * lb;
            DIV:   if (lb == 0) err = 1'b1; else r = la / lb;
            MOD:   if (lb == 0) err = 1'b1; else r = la % lb;
            POW: begin
                if (lb < 0) err = 1'b1;
                else begin
                    r = 1;
                    for (longint i = 0; i < lb; i++) r = (r * la) & 64'hFFFF;
                end
            end
            default: err = 1'b1;
        endcase
        res = r[15:0];
    endfunction

    function automatic logic [37:0] exp_slot(input int p);
        return {m_vld[p], m_opc[p], m_a[p], m_b[p], m_res[p], m_err[p]};
    endfunction

    function automatic logic [37:0] got_slot();
        return {bus.rd_valid, bus.rd_opcode, bus.rd_operand_a, bus.rd_operand_b,
                bus.rd_result, bus.rd_err};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_opc[i] = ZERO; m_a[i] = '0; m_b[i] = '0;
            m_res[i] = '0;   m_err[i] = 1'b0; m_vld[i] = 1'b0;
        end
    endtask

    task automatic model_write(input opcode_t op, input logic [7:0] a,
                               input logic [7:0] b, input int p);
        logic [15:0] r;
        logic        e;
        ref_calc(op, a, b, r, e);
        m_opc[p] = op; m_a[p] = a; m_b[p] = b; m_res[p] = r; m_err[p] = e; m_vld[p] = 1'b1;
    endtask

    task automatic peek(input int p);
        bus.read_pointer = 3'(p);
        #1;
    endtask

    // Starts and ends just after a falling edge. Returns the number of cycles
    // load_ready stayed low after acceptance and the cycles where busy disagreed.
    task automatic issue(input opcode_t op, input logic [7:0] a, input logic [7:0] b,
                         input int p, output int low, output int bb);
        int n = 0;
        bus.opcode        = op;
        bus.operand_a     = a;
        bus.operand_b     = b;
        bus.write_pointer = 3'(p);
        bus.load_valid    = 1'b1;
        while (bus.load_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL issue_wait_ready got=%0d cycles required<100", n);
        end
        model_write(op, a, b, p);
        @(negedge clk);
        bus.load_valid = 1'b0;
        low = 0;
        bb  = 0;
        while (bus.load_ready !== 1'b1 && low < 100) begin
            if (bus.busy !== 1'b1) bb++;
            low++;
            @(negedge clk);
        end
        if (bus.busy !== 1'b0) bb++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        total++;
        if (bus.load_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_ready ready=%b busy=%b required 1/0", bus.load_ready, bus.busy);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int p = 0; p < DEPTH; p++) begin
            peek(p);
            total++;
            if (got_slot() !== exp_slot(p)) begin
                bad++; $display("FAIL reset_slot p=%0d got=%h required=%h", p, got_slot(), exp_slot(p));
            end
        end
        total++;
        if (bus.load_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL post_reset_ready ready=%b busy=%b required 1/0", bus.load_ready, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        opcode_t     ops  [3] = '{ADD, SUB, MULT};
        logic [7:0]  av   [3] = '{8'd100, 8'h80, 8'h80};
        logic [7:0]  bv   [3] = '{8'd100, 8'd1, 8'h80};
        int          pp   [3] = '{1, 2, 3};
        logic [15:0] want [3] = '{16'd200, 16'hFF7F, 16'h4000};
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                bus.opcode = ops[k]; bus.operand_a = av[k]; bus.operand_b = bv[k];
                bus.write_pointer = 3'(pp[k]); bus.load_valid = 1'b1;
                model_write(ops[k], av[k], bv[k], pp[k]);
            end else begin
                bus.load_valid = 1'b0;
            end
            total++;
            if (bus.load_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_ready k=%0d got=%b required=1", k, bus.load_ready);
            end
            if (k >= 1 && k <= 3) begin
                peek(pp[k-1]);
                total++;
                if (bus.rd_valid !== 1'b0) begin
                    bad++; $display("FAIL b2b_no_bypass p=%0d valid=%b required=0", pp[k-1], bus.rd_valid);
                end
            end
            if (k >= 2) begin
                peek(pp[k-2]);
                total++;
                if (bus.rd_result !== want[k-2] || bus.rd_valid !== 1'b1 || got_slot() !== exp_slot(pp[k-2])) begin
                    bad++; $display("FAIL b2b_result p=%0d got=%h required res=%h slot=%h",
                                    pp[k-2], got_slot(), want[k-2], exp_slot(pp[k-2]));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_iter_timing();
        opcode_t     ops  [2] = '{DIV, MOD};
        logic [15:0] want [2] = '{16'hFFFD, 16'hFFFF};
        int low, bb;
        for (int k = 0; k < 2; k++) begin
            issue(ops[k], 8'hF9, 8'd2, 4 + k, low, bb);
            total++;
            if (low !== ITER_LOW) begin
                bad++; $display("FAIL iter_ready_low op=%0d got=%0d required=%0d", ops[k], low, ITER_LOW);
            end
            total++;
            if (bb !== 0) begin
                bad++; $display("FAIL iter_busy_mirror op=%0d mismatches=%0d required=0", ops[k], bb);
            end
            peek(4 + k);
            total++;
            if (bus.rd_result !== want[k] || got_slot() !== exp_slot(4 + k)) begin
                bad++; $display("FAIL iter_result p=%0d got=%h required res=%h slot=%h",
                                4 + k, got_slot(), want[k], exp_slot(4 + k));
            end
        end
    endtask

    task automatic test_iter_errors();
        opcode_t     ops  [6] = '{DIV, POW, POW, POW, opcode_t'(4'hF), MOD};
        logic [7:0]  av   [6] = '{8'd5, 8'd3, 8'd3, 8'd2, 8'd9, 8'd7};
        logic [7:0]  bv   [6] = '{8'd0, 8'hFF, 8'd4, 8'd0, 8'd1, 8'd0};
        logic [15:0] wres [6] = '{16'd0, 16'd0, 16'd81, 16'd1, 16'd0, 16'd0};
        logic        werr [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int low, bb;
        for (int k = 0; k < 6; k++) begin
            issue(ops[k], av[k], bv[k], k, low, bb);
            @(negedge clk);
            total++;
            if (low !== (is_iterative(ops[k]) ? ITER_LOW : 0)) begin
                bad++; $display("FAIL err_case_latency k=%0d got=%0d", k, low);
            end
            peek(k);
            total++;
            if (bus.rd_result !== wres[k] || bus.rd_err !== werr[k] || got_slot() !== exp_slot(k)) begin
                bad++; $display("FAIL err_case k=%0d got=%h required res=%h err=%b slot=%h",
                                k, got_slot(), wres[k], werr[k], exp_slot(k));
            end
        end
    endtask

    task automatic test_reset_mid_iter();
        bus.opcode = POW; bus.operand_a = 8'd2; bus.operand_b = 8'd7;
        bus.write_pointer = 3'd6; bus.load_valid = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        total++;
        if (bus.load_ready !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL pow_started ready=%b busy=%b required 0/1", bus.load_ready, bus.busy);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        model_clear();
        #1;
        total++;
        if (bus.load_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL abort_ready ready=%b busy=%b required 1/0", bus.load_ready, bus.busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        peek(6);
        total++;
        if (got_slot() !== exp_slot(6) || bus.load_ready !== 1'b1) begin
            bad++; $display("FAIL abort_not_written got=%h ready=%b required=%h ready 1",
                            got_slot(), bus.load_ready, exp_slot(6));
        end
    endtask

    task automatic test_same_edge();
        logic [37:0] old;
        int low, bb;
        @(negedge clk);
        old = exp_slot(7);
        bus.opcode = PASSA; bus.operand_a = 8'd77; bus.operand_b = 8'($urandom);
        bus.write_pointer = 3'd7; bus.load_valid = 1'b1;
        bus.read_pointer = 3'd7;
        model_write(PASSA, 8'd77, bus.operand_b, 7);
        @(negedge clk);
        bus.load_valid = 1'b0;
        peek(7);
        total++;
        if (got_slot() !== old) begin
            bad++; $display("FAIL same_edge_old got=%h required=%h", got_slot(), old);
        end
        @(negedge clk);
        peek(7);
        total++;
        if (got_slot() !== exp_slot(7) || bus.rd_result !== 16'd77) begin
            bad++; $display("FAIL same_edge_new got=%h required=%h", got_slot(), exp_slot(7));
        end
        issue(PASSB, 8'($urandom), 8'd5, 7, low, bb);
        @(negedge clk);
        peek(7);
        total++;
        if (bus.rd_result !== 16'd5 || got_slot() !== exp_slot(7)) begin
            bad++; $display("FAIL overwrite got=%h required=%h", got_slot(), exp_slot(7));
        end
    endtask

    task automatic test_random();
        int low, bb, p, r;
        opcode_t op;
        for (int k = 0; k < 30; k++) begin
            r  = int'($urandom_range(0, 9));
            op = (r == 9) ? opcode_t'(4'($urandom_range(9, 15))) : opcode_t'(4'(r));
            p  = int'($urandom_range(0, DEPTH - 1));
            issue(op, 8'($urandom), 8'($urandom), p, low, bb);
            @(negedge clk);
            peek(p);
            total++;
            if (got_slot() !== exp_slot(p) || low !== (is_iterative(op) ? ITER_LOW : 0) || bb !== 0) begin
                bad++; $display("FAIL random k=%0d op=%0d p=%0d got=%h required=%h low=%0d busybad=%0d",
                                k, op, p, got_slot(), exp_slot(p), low, bb);
            end
        end
    endtask

    task automatic test_random_burst();
        opcode_t    op;
        logic [7:0] a, b;
        int         p;
        for (int k = 0; k < 13; k++) begin
            if (k < 12) begin
                op = opcode_t'(4'($urandom_range(0, 5)));
                a  = 8'($urandom); b = 8'($urandom);
                p  = int'($urandom_range(0, 2));
                bus.opcode = op; bus.operand_a = a; bus.operand_b = b;
                bus.write_pointer = 3'(p); bus.load_valid = 1'b1;
                model_write(op, a, b, p);
            end else begin
                bus.load_valid = 1'b0;
            end
            total++;
            if (bus.load_ready !== 1'b1) begin
                bad++; $display("FAIL burst_ready k=%0d got=%b required=1", k, bus.load_ready);
            end
            @(negedge clk);
        end
        for (int q = 0; q < DEPTH; q++) begin
            peek(q);
            total++;
            if (got_slot() !== exp_slot(q)) begin
                bad++; $display("FAIL burst_slot p=%0d got=%h required=%h", q, got_slot(), exp_slot(q));
            end
        end
    endtask

    initial begin
        bus.load_valid    = 1'b0;
        bus.opcode        = ZERO;
        bus.operand_a     = '0;
        bus.operand_b     = '0;
        bus.write_pointer = '0;
        bus.read_pointer  = '0;
        #2;
        test_reset();
        test_back_to_back();
        test_iter_timing();
        test_iter_errors();
        test_reset_mid_iter();
        test_same_edge();
        test_random();
        test_random_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/instr_register_pipe.md
Name: instr_register_pipe

Overview:
- Parametrised next-generation instruction register file; each slot stores opcode, two signed operands, computed result and an error flag.
- Loads use a valid/ready handshake into a one-stage writeback pipeline.
- ZERO/PASSA/PASSB/ADD/SUB/MULT complete in one cycle at full throughput; DIV/MOD/POW run on an iterative sequential unit that stalls the load port.
- Sits between the stimulus/decode side and any consumer reading results by pointer.

Parameters:
OP_WIDTH, 32, operand width in bits, signed two's complement, >= 2
DEPTH, 32, number of register slots, power of two, >= 2
AW, $clog2(DEPTH), pointer width; derived, not overridden
RES_WIDTH, 2*OP_WIDTH, result width; derived

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
load_valid  in  1  load request
load_ready  out  1  block can accept a load this cycle
opcode  in  opcode_t  operation
operand_a  in  OP_WIDTH  signed operand A
operand_b  in  OP_WIDTH  signed operand B
write_pointer  in  AW  destination slot
read_pointer  in  AW  slot to read
rd_opcode  out  opcode_t  opcode of slot[read_pointer]
rd_operand_a  out  OP_WIDTH  stored A
rd_operand_b  out  OP_WIDTH  stored B
rd_result  out  RES_WIDTH  stored result
rd_err  out  1  stored error flag
rd_valid  out  1  slot written since reset
busy  out  1  iterative op in progress

Behaviour:
- Reset (async, any state, including mid-iteration):
  - All slots cleared to opc=ZERO, operands/result 0, err 0, valid 0.
  - Pipeline stage invalid, FSM to IDLE.
  - Any iterative op is aborted and not written.
  - load_ready=1 and busy=0 while reset asserted and after release.
- Read port: purely combinational from the slot array. A slot being written on edge E shows the new data only after E (no bypass).
- Handshake:
  - Transfer occurs on an edge where load_valid && load_ready.
  - Inputs are ignored when load_ready=0; the requester holds them until accepted.
- Single-cycle ops, accepted at edge N:
  - Captured into the stage register at N; slot written at N+1 with valid=1.
  - load_ready stays 1, so back-to-back loads write one slot per cycle.
- Iterative ops (DIV, MOD, POW), accepted at edge N:
  - FSM IDLE->ITER at N; load_ready=0 and busy=1 from N until the writeback edge.
  - ITER lasts exactly OP_WIDTH cycles; ITER->WB; slot written at edge N+OP_WIDTH+1; WB->IDLE on the same edge.
  - load_ready returns to 1 in the cycle after that edge.
  - A single-cycle op still in the stage register at N drains at N+1 as normal.
- FSM states: IDLE, ITER, WB. No other transitions.
- Arithmetic (result sign-extended/exact in RES_WIDTH unless stated):
  - ZERO: 0.
  - PASSA: A. PASSB: B.
  - ADD: A+B. SUB: A-B. MULT: A*B, all exact.
  - DIV: quotient truncated toward zero. MOD: remainder, sign follows A.
  - DIV or MOD with B==0: result 0, err=1.
  - POW: A**B via square-and-multiply over the B bits, low RES_WIDTH bits kept. B<0: result 0, err=1. B==0: result 1.
  - Illegal opcode encoding: single-cycle path, result 0, err=1.
  - err=0 in every other case.
- Write collision: two consecutive loads to the same pointer mean the later one wins; each write is a full-slot overwrite.
- Pointer wrap: pointers are exactly AW bits, so there is no out-of-range case.

Decomposition:
- instr_register_pkg holds:
  - opcode_t (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD, POW; 4-bit encoding)
  - iter_state_t (IDLE, ITER, WB)
  - function is_iterative(opcode_t)
- The slot struct stays inside the module because its field widths depend on the parameters.
- One sub-module, instr_iter_unit:
  - Holds the restoring signed divider and the square-and-multiply power engine.
  - start/done handshake; fixed latency of OP_WIDTH cycles.

Test Plan (OP_WIDTH=8, DEPTH=8):
1. Reset, then read slots 0..7 -> rd_valid=0, rd_opcode=ZERO, rd_result=0, load_ready=1.
2. Back-to-back ADD 100+100 ->slot1, SUB -128-1 ->slot2, MULT -128*-128 ->slot3 -> results 200, -129, 16384, each visible one cycle after acceptance; load_ready never drops.
3. DIV -7/2 ->slot4, then MOD -7%2 ->slot5 -> load_ready low for exactly 9 cycles per op; slot4=-3, slot5=-1; busy mirrors ~load_ready.
4. DIV 5/0 and POW 3**-1 -> result 0, err=1; POW 3**4=81, err=0; POW 2**0=1.
5. Reset asserted 3 cycles into POW 2**7 ->slot6 -> slot6 rd_valid=0, FSM IDLE, load_ready=1 immediately.
6. Read slot7 on the same edge it is written -> old value that cycle, new value next cycle; reload slot7 with PASSB 5 -> overwrite, rd_result=5.
